// File: rtl/button_event_sched.sv
// Round-robin scheduler that turns per-button press/release pulses into a queued event stream.
// Define BTN_SCHED_RELEASE_EN to also queue release events (i_neg); otherwise i_neg is ignored.
module button_event_sched #(
  parameter int unsigned NUM_BTNS   = 25,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BTNS-1:0] i_pos,
  input  logic [NUM_BTNS-1:0] i_neg,
  input  logic                i_clear,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [4:0]          o_idx,
  output logic                o_release,
  output logic [NUM_BTNS-1:0] o_pending,
  output logic [3:0]          o_count,
  output logic                o_overflow
);

  localparam int unsigned IdxW  = 5;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_BTNS - 1);
  localparam logic [3:0]      DepthCnt = 4'(FIFO_DEPTH);

  // Returns {found, idx}: lowest set request at or above ptr, else lowest set request overall.
  function automatic logic [IdxW:0] rr_pick(input logic [NUM_BTNS-1:0] req,
                                           input logic [IdxW-1:0]     ptr);
    logic            found;
    logic [IdxW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = IdxW'(i);
      end
    end
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = IdxW'(i);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  logic [NUM_BTNS-1:0] pend_press_q, pend_press_d;
  logic [IdxW-1:0]     rr_press_q, rr_press_d;
  logic                ovf_q, ovf_d;
  logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]          count_q, count_d;
  logic [IdxW:0]       mem_q [FIFO_DEPTH];

  logic                can_push;
  logic [IdxW:0]       press_pick;
  logic                press_gnt;
  logic [NUM_BTNS-1:0] press_gnt_vec;
  logic                push;
  logic                pop;
  logic [IdxW:0]       push_data;
  logic [IdxW:0]       head;

  // A push never waits on a same-cycle pop, so a full FIFO blocks grants for the whole cycle.
  assign can_push      = (count_q < DepthCnt);
  assign press_pick    = rr_pick(pend_press_q, rr_press_q);
  assign press_gnt     = can_push & press_pick[IdxW];
  assign press_gnt_vec = press_gnt ? (NUM_BTNS'(1) << press_pick[IdxW-1:0]) : '0;
  assign pop           = (count_q != 4'd0) & i_ready;
  assign head          = mem_q[rd_ptr_q];

`ifdef BTN_SCHED_RELEASE_EN
  logic [NUM_BTNS-1:0] pend_rel_q, pend_rel_d;
  logic [IdxW-1:0]     rr_rel_q, rr_rel_d;
  logic [IdxW:0]       rel_pick;
  logic                rel_gnt;
  logic [NUM_BTNS-1:0] rel_gnt_vec;

  // Releases only win arbitration once every press has been queued.
  assign rel_pick    = rr_pick(pend_rel_q, rr_rel_q);
  assign rel_gnt     = can_push & ~(|pend_press_q) & rel_pick[IdxW];
  assign rel_gnt_vec = rel_gnt ? (NUM_BTNS'(1) << rel_pick[IdxW-1:0]) : '0;
  assign push        = press_gnt | rel_gnt;
  assign push_data   = press_gnt ? {1'b0, press_pick[IdxW-1:0]} : {1'b1, rel_pick[IdxW-1:0]};
  assign o_release   = o_valid & head[IdxW];

  always_comb begin
    pend_rel_d = (pend_rel_q & ~rel_gnt_vec) | i_neg;
    rr_rel_d   = rel_gnt ? rr_next(rel_pick[IdxW-1:0]) : rr_rel_q;
    if (i_clear) begin
      pend_rel_d = '0;
      rr_rel_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_rel_q <= '0;
      rr_rel_q   <= '0;
    end else begin
      pend_rel_q <= pend_rel_d;
      rr_rel_q   <= rr_rel_d;
    end
  end
`else
  logic unused_sink;

  assign push        = press_gnt;
  assign push_data   = {1'b0, press_pick[IdxW-1:0]};
  assign o_release   = 1'b0;
  assign unused_sink = ^{i_neg, head[IdxW]};
`endif

  always_comb begin
    pend_press_d = (pend_press_q & ~press_gnt_vec) | i_pos;
    rr_press_d   = press_gnt ? rr_next(press_pick[IdxW-1:0]) : rr_press_q;
    ovf_d        = ovf_q | (|(i_pos & pend_press_q & ~press_gnt_vec));
`ifdef BTN_SCHED_RELEASE_EN
    ovf_d        = ovf_d | (|(i_neg & pend_rel_q & ~rel_gnt_vec));
`endif
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (i_clear) begin
      pend_press_d = '0;
      rr_press_d   = '0;
      ovf_d        = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_press_q <= '0;
      rr_press_q   <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pend_press_q <= pend_press_d;
      rr_press_q   <= rr_press_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push && !i_clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign o_valid    = (count_q != 4'd0);
  assign o_idx      = o_valid ? head[IdxW-1:0] : '0;
  assign o_pending  = pend_press_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_button_event_sched.sv
// Scoreboard bench for button_event_sched: expected events are queued as stimulus is driven and
// checked in order as the consumer accepts them.
module tb_button_event_sched;

  localparam int unsigned NB = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] pos;
  logic [NB-1:0] neg;
  logic          clear;
  logic          ready;
  logic          valid;
  logic [4:0]    idx;
  logic          rel;
  logic [NB-1:0] pending;
  logic [3:0]    count;
  logic          ovf;

  typedef logic [5:0] ev_t;
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  button_event_sched #(
    .NUM_BTNS  (NB),
    .FIFO_DEPTH(8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_pos     (pos),
    .i_neg     (neg),
    .i_clear   (clear),
    .i_ready   (ready),
    .o_valid   (valid),
    .o_idx     (idx),
    .o_release (rel),
    .o_pending (pending),
    .o_count   (count),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic ev_t ev(input logic r, input int b);
    return {r, 5'(b)};
  endfunction

  function automatic logic [NB-1:0] bit_of(input int b);
    return NB'(1) << b;
  endfunction

  // Consumer side: an accepted head event must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && !clear && valid && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got rel=%0b idx=%0d, required no event", rel, idx);
      end else begin
        e = exp_q.pop_front();
        if ({rel, idx} !== e) begin
          n_fail++;
          $display("FAIL pop_order: got rel=%0b idx=%0d, required rel=%0b idx=%0d",
                   rel, idx, e[5], e[4:0]);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (count == 4'd0 && pending == '0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: o_count=%0d, required 0 within %0d cycles", count, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pos   = '0;
    neg   = '0;
    clear = 1'b0;
    ready = 1'b0;
    #12;
    n_checks++;
    if ({valid, idx, rel, pending, count, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b idx=%0d rel=%0b pend=%0h cnt=%0d ovf=%0b, required 0",
               valid, idx, rel, pending, count, ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    ready = 1'b1;
    pos   = bit_of(3);
    exp_q.push_back(ev(0, 3));
    cycle();
    pos = '0;
    n_checks++;
    if (valid !== 1'b0 || pending !== bit_of(3)) begin
      n_fail++;
      $display("FAIL single_pending: got v=%0b pend=%0h, required v=0 pend=%0h",
               valid, pending, bit_of(3));
    end
    cycle();
    n_checks++;
    if (valid !== 1'b1 || idx !== 5'd3 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_latency: got v=%0b idx=%0d cnt=%0d, required v=1 idx=3 cnt=1",
               valid, idx, count);
    end
    cycle();
    n_checks++;
    if (count !== 4'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got cnt=%0d v=%0b, required cnt=0 v=0", count, valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] req;
    ready = 1'b1;
    pos   = bit_of(5);
    exp_q.push_back(ev(0, 5));
    cycle();
    pos = '0;
    wait_empty(20);
    req = bit_of(24) | bit_of(0) | bit_of(5);
    pos = req;
    exp_q.push_back(ev(0, 24));
    exp_q.push_back(ev(0, 0));
    exp_q.push_back(ev(0, 5));
    cycle();
    pos = '0;
    n_checks++;
    if (pending !== req) begin
      n_fail++;
      $display("FAIL rr_pending: got %0h, required %0h", pending, req);
    end
    cycle();
    n_checks++;
    if (count !== 4'd1 || idx !== 5'd24) begin
      n_fail++;
      $display("FAIL rr_first: got cnt=%0d idx=%0d, required cnt=1 idx=24", count, idx);
    end
    cycle();
    n_checks++;
    if (count !== 4'd1 || idx !== 5'd0) begin
      n_fail++;
      $display("FAIL rr_push_pop: got cnt=%0d idx=%0d, required cnt=1 idx=0", count, idx);
    end
    wait_empty(20);
    // Pointer should now sit at 6, so 6 beats 5.
    pos = bit_of(5) | bit_of(6);
    exp_q.push_back(ev(0, 6));
    exp_q.push_back(ev(0, 5));
    cycle();
    pos = '0;
    wait_empty(20);
    n_checks++;
    if (exp_q.size() != 0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got left=%0d ovf=%0b, required left=0 ovf=0", exp_q.size(), ovf);
    end
  endtask

  task automatic test_full();
    ready = 1'b0;
    pos   = '0;
    for (int b = 10; b <= 18; b++) begin
      pos[b] = 1'b1;
      exp_q.push_back(ev(0, b));
    end
    cycle();
    pos = '0;
    repeat (9) cycle();
    n_checks++;
    if (count !== 4'd8 || pending !== bit_of(18) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stall: got cnt=%0d pend=%0h ovf=%0b, required cnt=8 pend=%0h ovf=0",
               count, pending, ovf, bit_of(18));
    end
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    n_checks++;
    if (count !== 4'd7 || pending !== bit_of(18)) begin
      n_fail++;
      $display("FAIL full_pop: got cnt=%0d pend=%0h, required cnt=7 pend=%0h",
               count, pending, bit_of(18));
    end
    cycle();
    n_checks++;
    if (count !== 4'd8 || pending !== '0) begin
      n_fail++;
      $display("FAIL full_refill: got cnt=%0d pend=%0h, required cnt=8 pend=0", count, pending);
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    pos   = bit_of(7);
    cycle();
    pos = '0;
    n_checks++;
    if (ovf !== 1'b0 || pending !== bit_of(7)) begin
      n_fail++;
      $display("FAIL ovf_first: got ovf=%0b pend=%0h, required ovf=0 pend=%0h",
               ovf, pending, bit_of(7));
    end
    cycle();
    pos = bit_of(7);
    exp_q.push_back(ev(0, 7));
    cycle();
    pos = '0;
    n_checks++;
    if (ovf !== 1'b1 || pending !== bit_of(7) || count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_coalesce: got ovf=%0b pend=%0h cnt=%0d, required ovf=1 pend=%0h cnt=8",
               ovf, pending, count, bit_of(7));
    end
    ready = 1'b1;
    wait_empty(40);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_drain: got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_release();
    ready = 1'b1;
    pos   = bit_of(2);
    exp_q.push_back(ev(0, 2));
    cycle();
    pos = '0;
    neg = bit_of(2);
`ifdef BTN_SCHED_RELEASE_EN
    exp_q.push_back(ev(1, 2));
`endif
    cycle();
    neg = '0;
    wait_empty(20);
    cycle();
    n_checks++;
    if (exp_q.size() != 0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_events: got left=%0d v=%0b, required left=0 v=0", exp_q.size(), valid);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    pos   = '0;
    for (int b = 0; b < 5; b++) pos[b] = 1'b1;
    cycle();
    pos = '0;
    repeat (5) cycle();
    n_checks++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_fill: got cnt=%0d, required 5", count);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if ({valid, idx, rel, pending, count, ovf} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b idx=%0d rel=%0b pend=%0h cnt=%0d ovf=%0b, required 0",
               valid, idx, rel, pending, count, ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Arbitration restarts at 0, so 2 beats 20.
    ready = 1'b1;
    pos   = bit_of(2) | bit_of(20);
    exp_q.push_back(ev(0, 2));
    exp_q.push_back(ev(0, 20));
    cycle();
    pos = '0;
    wait_empty(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_restart: got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_clear();
    ready = 1'b0;
    pos   = bit_of(4) | bit_of(5);
    cycle();
    pos = bit_of(5);
    cycle();
    pos = '0;
    n_checks++;
    if (ovf !== 1'b1 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL clear_setup: got ovf=%0b cnt=%0d, required ovf=1 cnt=1", ovf, count);
    end
    cycle();
    clear = 1'b1;
    pos   = bit_of(1) | bit_of(9);
    cycle();
    clear = 1'b0;
    pos   = '0;
    exp_q.delete();
    n_checks++;
    if (count !== 4'd0 || pending !== '0 || ovf !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flush: got cnt=%0d pend=%0h ovf=%0b v=%0b, required all 0",
               count, pending, ovf, valid);
    end
    cycle();
    n_checks++;
    if (count !== 4'd0 || pending !== '0) begin
      n_fail++;
      $display("FAIL clear_discard: got cnt=%0d pend=%0h, required cnt=0 pend=0", count, pending);
    end
    ready = 1'b1;
    pos   = bit_of(1) | bit_of(20);
    exp_q.push_back(ev(0, 1));
    exp_q.push_back(ev(0, 20));
    cycle();
    pos = '0;
    wait_empty(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clear_restart: got left=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_overflow();
    test_release();
    test_reset_mid();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
